// File: rtl/count8_seq.sv
// -----------------------------------------------------------------------------
// count8_seq : command sequencer driving an 8-bit loadable counter.
//
// Accepts a (start, length) command over a valid/ready handshake, strobes
// load for one cycle with the start value, then issues exactly `length`
// enable cycles (paused while hold is high), and finally pulses done.
// The counter's output is fed back so the expected count can be tracked
// and, optionally, checked.
//
// Configuration macro: COUNT8_SEQ_CHECK_EN
//   defined   -> adds sticky output err, set when CNT != exp_cnt in RUN/DONE
//   undefined -> no err port, CNT is unused
//
// Ports:
//   clk        in   rising-edge clock (shared with the counter)
//   res        in   synchronous reset, active-high
//   cmd_valid  in   command offered
//   cmd_ready  out  sequencer can accept a command (IDLE and not in reset)
//   cmd_start  in   value to load into the counter
//   cmd_len    in   number of enable cycles to issue (0..2^WIDTH-1)
//   hold       in   pause, suppresses EN while high
//   CNT        in   counter output, fed back
//   EN         out  counter enable
//   load       out  counter load strobe
//   CNT_In     out  counter load value
//   busy       out  sequencer is not IDLE
//   done       out  one-cycle completion pulse
//   rem        out  enable cycles still to issue
//   exp_cnt    out  expected counter value
//   err        out  (COUNT8_SEQ_CHECK_EN only) sticky count mismatch flag
// -----------------------------------------------------------------------------
module count8_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             res,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_start,
    input  logic [WIDTH-1:0] cmd_len,
    input  logic             hold,
    input  logic [WIDTH-1:0] CNT,
    output logic             EN,
    output logic             load,
    output logic [WIDTH-1:0] CNT_In,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] rem,
    output logic [WIDTH-1:0] exp_cnt
`ifdef COUNT8_SEQ_CHECK_EN
    ,
    output logic             err
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO = WIDTH'(0);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] exp_cnt_q, exp_cnt_d;
    logic [WIDTH-1:0] cnt_in_q, cnt_in_d;
    logic             done_q, done_d;

    logic             accept_s;
    logic             en_s;

    // Handshake and strobes are gated by res so nothing leaks out during reset.
    assign cmd_ready = (state_q == IDLE) & ~res;
    assign accept_s  = cmd_valid & cmd_ready;
    assign en_s      = (state_q == RUN) & ~hold & ~res;

    assign EN      = en_s;
    assign load    = (state_q == LOAD) & ~res;
    assign CNT_In  = cnt_in_q;
    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign rem     = rem_q;
    assign exp_cnt = exp_cnt_q;

    // Next-state logic: command accept, load, counted enables, completion.
    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        exp_cnt_d = exp_cnt_q;
        cnt_in_d  = cnt_in_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    cnt_in_d  = cmd_start;
                    rem_d     = cmd_len;
                    exp_cnt_d = cmd_start;
                    state_d   = LOAD;
                end else begin
                    state_d   = IDLE;
                end
            end
            LOAD: begin
                // A zero-length command skips RUN entirely.
                if (rem_q == ZERO) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (en_s) begin
                    rem_d     = rem_q - ONE;
                    exp_cnt_d = exp_cnt_q + ONE;
                    // Leave on the edge that issues the final enable.
                    if (rem_q == ONE) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end else begin
                    state_d = RUN;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (res) begin
            state_q   <= IDLE;
            rem_q     <= ZERO;
            exp_cnt_q <= ZERO;
            cnt_in_q  <= ZERO;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            exp_cnt_q <= exp_cnt_d;
            cnt_in_q  <= cnt_in_d;
            done_q    <= done_d;
        end
    end

`ifdef COUNT8_SEQ_CHECK_EN
    logic err_q, err_d;

    assign err = err_q;

    // Sticky mismatch flag; a new command clears it.
    always_comb begin
        err_d = err_q;
        if (accept_s) begin
            err_d = 1'b0;
        end else if (((state_q == RUN) || (state_q == DONE)) && (CNT != exp_cnt_q)) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
    end

    // Error flag register with synchronous reset.
    always_ff @(posedge clk) begin
        if (res) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`else
    // Counter feedback is only consumed by the optional checker.
    logic unused_cnt_s;
    assign unused_cnt_s = ^CNT;
`endif

endmodule
